// File: rtl/wk_fetch_pkg.sv
// Shared types and constants for the weight-ROM fetch controller.
//   fetch_state_t : controller FSM states
//   ROM_LAT       : registered-read latency of the weight ROM, in cycles
//   PIPE_DEPTH    : tag pipeline depth covering rom_add register + ROM latency
//   beat_tag_t    : per-beat tag {valid, id, last} travelling alongside the ROM read
package wk_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } fetch_state_t;

  localparam int ROM_LAT    = 1;
  localparam int PIPE_DEPTH = ROM_LAT + 1;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
    logic               last;
  } beat_tag_t;

endpackage

// File: rtl/wk_rr_arb.sv
// Combinational round-robin picker.
//   i_req  : request vector
//   i_ptr  : index with highest priority this round
//   o_oh   : one-hot winner (all zero when no request)
//   o_idx  : encoded winner index
//   o_any  : at least one request is pending
module wk_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_oh,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_k;

  // Scan offsets from farthest to nearest so the request closest to the
  // pointer (searching upward with wrap) is the last one written and wins.
  always_comb begin
    o_oh  = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_k = int'(i_ptr) + off;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      if (i_req[w_k]) begin
        o_any = 1'b1;
        o_idx = IDW'(w_k);
        o_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_k;
      end
    end
  end

endmodule

// File: rtl/wk_fetch_ctrl.sv
// Burst fetch controller sharing one registered-read weight ROM between
// NREQ requesters.
//   i_CS          : clock
//   i_cen         : asynchronous active-low reset
//   i_req         : per-requester burst request (level, held until o_gnt)
//   i_start_addr  : packed start addresses, requester i at [i*AW +: AW]
//   i_burst_len   : packed burst lengths,   requester i at [i*LW +: LW]
//   o_gnt         : one-hot accept pulse
//   o_busy        : controller not idle
//   o_rom_add     : registered ROM address
//   i_rom_data    : registered ROM read data
//   o_rd_data/o_rd_valid/o_rd_id/o_rd_last : returned beat
//   o_done        : one-hot burst completion pulse
module wk_fetch_ctrl
  import wk_fetch_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int LW   = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             i_CS,
  input  logic             i_cen,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ*AW-1:0] i_start_addr,
  input  logic [NREQ*LW-1:0] i_burst_len,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_busy,
  output logic [AW-1:0]    o_rom_add,
  input  logic [DW-1:0]    i_rom_data,
  output logic [DW-1:0]    o_rd_data,
  output logic             o_rd_valid,
  output logic [IDW-1:0]   o_rd_id,
  output logic             o_rd_last,
  output logic [NREQ-1:0]  o_done
);

  fetch_state_t    r_state, w_state_next;
  logic [IDW-1:0]  r_ptr, r_id;
  logic [AW-1:0]   r_cur;
  logic [LW-1:0]   r_rem;
  beat_tag_t       r_pipe [PIPE_DEPTH];
  beat_tag_t       w_tail;

  logic [NREQ-1:0] w_win_oh;
  logic [IDW-1:0]  w_win_idx;
  logic            w_win_any;
  logic            w_accept, w_issue, w_finish;

  logic [AW-1:0]   w_start [NREQ];
  logic [LW-1:0]   w_len   [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_start[gi] = i_start_addr[gi*AW +: AW];
      assign w_len[gi]   = i_burst_len[gi*LW +: LW];
    end
  endgenerate

  wk_rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_req(i_req),
    .i_ptr(r_ptr),
    .o_oh (w_win_oh),
    .o_idx(w_win_idx),
    .o_any(w_win_any)
  );

  // Tag leaving the pipeline lines up with the ROM data for the same address.
  assign w_tail = r_pipe[PIPE_DEPTH-1];
  assign o_busy = (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_any) begin
          w_accept = 1'b1;
          // Zero-length bursts complete on the accept edge without a ROM access.
          if (w_len[w_win_idx] != '0) w_state_next = BURST;
        end
      end
      BURST: begin
        w_issue = 1'b1;
        if (r_rem == LW'(1)) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_tail.valid && w_tail.last) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_CS or negedge i_cen) begin
    if (!i_cen) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_cur      <= '0;
      r_rem      <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) r_pipe[i] <= '0;
      o_gnt      <= '0;
      o_done     <= '0;
      o_rom_add  <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_id    <= '0;
      o_rd_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      o_gnt   <= '0;
      o_done  <= '0;

      if (w_accept) begin
        o_gnt <= w_win_oh;
        r_id  <= w_win_idx;
        r_cur <= w_start[w_win_idx];
        r_rem <= w_len[w_win_idx];
        r_ptr <= (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + 1'b1;
        if (w_len[w_win_idx] == '0) o_done <= w_win_oh;
      end

      r_pipe[0] <= '0;
      if (w_issue) begin
        o_rom_add       <= r_cur;
        r_cur           <= r_cur + 1'b1;
        r_rem           <= r_rem - 1'b1;
        r_pipe[0].valid <= 1'b1;
        r_pipe[0].id    <= TAG_IDW'(r_id);
        r_pipe[0].last  <= (r_rem == LW'(1));
      end
      for (int i = 1; i < PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];

      o_rd_valid <= w_tail.valid;
      o_rd_last  <= w_tail.valid & w_tail.last;
      if (w_tail.valid) begin
        o_rd_data <= i_rom_data;
        o_rd_id   <= IDW'(w_tail.id);
      end

      if (w_finish) o_done <= {{(NREQ-1){1'b0}}, 1'b1} << r_id;
    end
  end

endmodule

// File: tb/tb_wk_fetch_ctrl.sv
// Directed self-checking bench for wk_fetch_ctrl with NREQ=2 and a ROM
// model holding 0 at address 0 and 2 everywhere else.
module tb_wk_fetch_ctrl;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LW   = 8;

  logic            clk;
  logic            cen;
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] start_addr;
  logic [NREQ*LW-1:0] burst_len;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [AW-1:0]   rom_add;
  logic [DW-1:0]   rom_data;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic [0:0]      rd_id;
  logic            rd_last;
  logic [NREQ-1:0] done;

  int n_checks = 0;
  int n_fail   = 0;

  wk_fetch_ctrl #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)
  ) dut (
    .i_CS        (clk),
    .i_cen       (cen),
    .i_req       (req),
    .i_start_addr(start_addr),
    .i_burst_len (burst_len),
    .o_gnt       (gnt),
    .o_busy      (busy),
    .o_rom_add   (rom_add),
    .i_rom_data  (rom_data),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_rd_id     (rd_id),
    .o_rd_last   (rd_last),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return (a == 8'd0) ? 8'd0 : 8'd2;
  endfunction

  // Registered-read ROM sharing the controller reset.
  always @(posedge clk or negedge cen) begin
    if (!cen) rom_data <= '0;
    else      rom_data <= rom_val(rom_add);
  end

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  // Called at the negedge before the expected accept edge; checks the grant,
  // every issued address and every returned beat, ending on the done cycle.
  task automatic do_burst(input int id, input logic [7:0] start, input logic [7:0] len,
                          input bit drop, input bit poke);
    logic [7:0] a;
    bit         fin;
    @(negedge clk);
    chk($sformatf("gnt%0d", id), 32'(gnt), 32'(1 << id));
    chk("busy_at_gnt", 32'(busy), 32'd1);
    $display("burst id=%0d start=%0d len=%0d granted", id, start, len);
    if (drop) req = '0;
    if (poke) start_addr[id*AW +: AW] = 8'hC8;
    for (int j = 1; j <= int'(len) + 2; j++) begin
      @(negedge clk);
      fin = (j == int'(len) + 2);
      if (j <= int'(len)) begin
        a = start + 8'(j - 1);
        chk($sformatf("rom_add_j%0d", j), 32'(rom_add), 32'(a));
      end
      if (j >= 3) begin
        a = start + 8'(j - 3);
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk($sformatf("rd_data_a%0d", a), 32'(rd_data), 32'(rom_val(a)));
        chk("rd_id", 32'(rd_id), 32'(id));
        chk("rd_last", 32'(rd_last), 32'(fin));
        $display("beat id=%0d addr=%0d data=%0d last=%0d", rd_id, a, rd_data, rd_last);
      end else begin
        chk("rd_valid_early", 32'(rd_valid), 32'd0);
      end
      chk("done", 32'(done), fin ? 32'(1 << id) : 32'd0);
      chk("busy", 32'(busy), fin ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    cen        = 1'b0;
    req        = '0;
    start_addr = '0;
    burst_len  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_add", 32'(rom_add), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    cen = 1'b1;
    @(negedge clk);

    // 1: req0 start=0 len=3
    start_addr[0 +: 8] = 8'd0;
    burst_len[0 +: 8]  = 8'd3;
    req = 2'b01;
    do_burst(0, 8'd0, 8'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_idle_valid", 32'(rd_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_hold_data", 32'(rd_data), 32'd2);
    chk("t1_hold_rom_add", 32'(rom_add), 32'd2);

    // 2: req1 start=254 len=4 (address wrap)
    start_addr[8 +: 8] = 8'd254;
    burst_len[8 +: 8]  = 8'd4;
    req = 2'b10;
    do_burst(1, 8'd254, 8'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_idle_valid", 32'(rd_valid), 32'd0);

    // 3: both held, len=2 each -> alternating grants, no interleaving
    start_addr = {8'd30, 8'd20};
    burst_len  = {8'd2, 8'd2};
    req = 2'b11;
    do_burst(0, 8'd20, 8'd2, 1'b0, 1'b0);
    do_burst(1, 8'd30, 8'd2, 1'b0, 1'b0);
    do_burst(0, 8'd20, 8'd2, 1'b0, 1'b0);
    do_burst(1, 8'd30, 8'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_no_gnt", 32'(gnt), 32'd0);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // 4: zero-length burst on req0
    burst_len[0 +: 8] = 8'd0;
    req = 2'b01;
    @(negedge clk);
    chk("t4_gnt0", 32'(gnt), 32'd1);
    chk("t4_done0", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rom_add", 32'(rom_add), 32'd31);
    $display("zero-length burst id=0 gnt=%b done=%b", gnt, done);
    req = 2'b00;
    @(negedge clk);
    chk("t4_done_clr", 32'(done), 32'd0);
    chk("t4_no_valid", 32'(rd_valid), 32'd0);
    chk("t4_rom_add2", 32'(rom_add), 32'd31);
    // Pointer moved to 1: a simultaneous request must go to requester 1.
    start_addr[8 +: 8] = 8'd40;
    burst_len = {8'd1, 8'd1};
    req = 2'b11;
    do_burst(1, 8'd40, 8'd1, 1'b1, 1'b0);

    // 5: async reset during second beat of a len=5 burst
    start_addr[0 +: 8] = 8'd100;
    burst_len[0 +: 8]  = 8'd5;
    req = 2'b01;
    @(negedge clk);
    chk("t5_gnt0", 32'(gnt), 32'd1);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("t5_beat2_valid", 32'(rd_valid), 32'd1);
    chk("t5_beat2_data", 32'(rd_data), 32'd2);
    cen = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_rom_add", 32'(rom_add), 32'd0);
    chk("t5_rst_rd_data", 32'(rd_data), 32'd0);
    chk("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_rst_rd_last", 32'(rd_last), 32'd0);
    chk("t5_rst_rd_id", 32'(rd_id), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    $display("reset asserted mid-burst, outputs cleared");
    @(negedge clk);
    cen = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_after_valid", 32'(rd_valid), 32'd0);
      chk("t5_after_done", 32'(done), 32'd0);
      chk("t5_after_busy", 32'(busy), 32'd0);
    end
    start_addr[8 +: 8] = 8'd10;
    burst_len[8 +: 8]  = 8'd1;
    req = 2'b10;
    do_burst(1, 8'd10, 8'd1, 1'b1, 1'b0);

    // 6: start_addr changed during BURST is ignored
    start_addr[0 +: 8] = 8'd50;
    burst_len[0 +: 8]  = 8'd3;
    req = 2'b01;
    do_burst(0, 8'd50, 8'd3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_valid", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
